// File: rtl/xorshift_pkg.sv
// xorshift_pkg: shared seed, xorshift64 step function and checker state type
//   SEED_BASE        model i is seeded with SEED_BASE + i
//   xorshift64_step  one xorshift64 step (<<13, >>7, <<17) on 64 bits
//   chk_state_e      checker FSM states
package xorshift_pkg;

    localparam logic [63:0] SEED_BASE = 64'hdeadbeefdeadbeef;

    typedef enum logic [1:0] {IDLE, RUN, HALT} chk_state_e;

    function automatic logic [63:0] xorshift64_step(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

endpackage

// File: rtl/xorshift_ref_bank.sv
// xorshift_ref_bank: per-CPU xorshift64 reference state registers
//   clk, rst_n   clock, asynchronous active-low reset (reseeds all models)
//   clear        synchronous reseed of all models, dominates a write
//   rd_idx       read port index; rd_data is 0 for an index outside the bank
//   wr_en/idx/data  single write port
module xorshift_ref_bank
    import xorshift_pkg::*;
#(
    parameter int NUM_CPUS = 4,
    parameter int IDX_W    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [63:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [63:0]      wr_data
);

    logic [63:0] model [NUM_CPUS];

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CPUS; i++)
            if (rd_idx == IDX_W'(i)) rd_data = model[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CPUS; i++) model[i] <= SEED_BASE + 64'(i);
        end else if (clear) begin
            for (int i = 0; i < NUM_CPUS; i++) model[i] <= SEED_BASE + 64'(i);
        end else if (wr_en) begin
            for (int i = 0; i < NUM_CPUS; i++)
                if (wr_idx == IDX_W'(i)) model[i] <= wr_data;
        end
    end

endmodule

// File: rtl/xorshift_stream_checker.sv
// xorshift_stream_checker: checks CPU-tagged 64-bit words against per-CPU xorshift64 models
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            level; start/keep checking
//   clear             sync pulse; reseed models, zero counters and capture, go IDLE
//   in_vld/in_rdy     word handshake; transfer when both high at posedge
//   in_cpu_idx        source CPU of the word
//   in_data           received word
//   match_cnt/err_cnt saturating match/mismatch counters
//   err_vld           sticky first-mismatch flag; err_cpu_idx/err_exp/err_got hold it
//   halted            FSM is in HALT
module xorshift_stream_checker
    import xorshift_pkg::*;
#(
    parameter int NUM_CPUS      = 4,
    parameter bit STOP_ON_ERR   = 1'b0,
    parameter bit RESYNC_ON_ERR = 1'b0,
    localparam int IDX_W        = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [IDX_W-1:0] in_cpu_idx,
    input  logic [63:0]      in_data,
    output logic [31:0]      match_cnt,
    output logic [31:0]      err_cnt,
    output logic             err_vld,
    output logic [IDX_W-1:0] err_cpu_idx,
    output logic [63:0]      err_exp,
    output logic [63:0]      err_got,
    output logic             halted
);

    chk_state_e       state;
    logic             stg_vld;
    logic [IDX_W-1:0] stg_idx;
    logic [63:0]      stg_data;
    logic [63:0]      model_q;
    logic [63:0]      exp_w;
    logic             idx_ok;
    logic             xfer;
    logic             hit;
    logic             mis;

    assign in_rdy = (state == RUN) && enable && !clear;
    assign xfer   = in_vld && in_rdy;
    assign halted = state == HALT;

    // An out-of-range index is always a mismatch against an expected word of 0
    assign idx_ok = 32'(stg_idx) < 32'(NUM_CPUS);
    assign exp_w  = idx_ok ? xorshift64_step(model_q) : '0;
    assign hit    = stg_vld && idx_ok && (exp_w == stg_data);
    assign mis    = stg_vld && !hit;

    // The model write at the end of the compare cycle is what the next staged word
    // reads, so back-to-back words from one CPU need no forwarding or stall
    xorshift_ref_bank #(.NUM_CPUS(NUM_CPUS), .IDX_W(IDX_W)) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .rd_idx  (stg_idx),
        .rd_data (model_q),
        .wr_en   (stg_vld && idx_ok),
        .wr_idx  (stg_idx),
        .wr_data ((mis && RESYNC_ON_ERR) ? xorshift64_step(stg_data) : exp_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            stg_vld     <= 1'b0;
            stg_idx     <= '0;
            stg_data    <= '0;
            match_cnt   <= '0;
            err_cnt     <= '0;
            err_vld     <= 1'b0;
            err_cpu_idx <= '0;
            err_exp     <= '0;
            err_got     <= '0;
        end else if (clear) begin
            state       <= IDLE;
            stg_vld     <= 1'b0;
            match_cnt   <= '0;
            err_cnt     <= '0;
            err_vld     <= 1'b0;
            err_cpu_idx <= '0;
            err_exp     <= '0;
            err_got     <= '0;
        end else begin
            stg_vld <= xfer;
            if (xfer) begin
                stg_idx  <= in_cpu_idx;
                stg_data <= in_data;
            end
            match_cnt <= match_cnt + 32'(hit && match_cnt != '1);
            err_cnt   <= err_cnt + 32'(mis && err_cnt != '1);
            if (mis && !err_vld) begin
                err_vld     <= 1'b1;
                err_cpu_idx <= stg_idx;
                err_exp     <= exp_w;
                err_got     <= stg_data;
            end
            case (state)
                IDLE:    state <= enable ? RUN : IDLE;
                RUN:     state <= (mis && STOP_ON_ERR) ? HALT
                                : (!enable && !stg_vld) ? IDLE : RUN;
                default: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_xorshift_stream_checker.sv
// tb_xorshift_stream_checker: directed and randomized checks of xorshift_stream_checker
module tb_xorshift_stream_checker;

    localparam logic [63:0] SEED = 64'hdeadbeefdeadbeef;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clear;
    logic        vld;
    logic [2:0]  idx_s;
    logic [63:0] data;
    int          sel;

    logic        rdy [3];
    logic [31:0] mc [3];
    logic [31:0] ec [3];
    logic        ev [3];
    logic [2:0]  ei [3];
    logic [63:0] ee [3];
    logic [63:0] eg [3];
    logic        hl [3];
    logic [1:0]  ei_a;
    logic [2:0]  ei_b;
    logic [1:0]  ei_c;

    always #5 clk = ~clk;

    // A: 4 CPUs, keep checking. B: 5 CPUs (room for an invalid index), resync. C: 4 CPUs, stop.
    xorshift_stream_checker #(.NUM_CPUS(4), .STOP_ON_ERR(1'b0), .RESYNC_ON_ERR(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en && sel == 0), .clear(clear),
        .in_vld(vld && sel == 0), .in_rdy(rdy[0]), .in_cpu_idx(idx_s[1:0]), .in_data(data),
        .match_cnt(mc[0]), .err_cnt(ec[0]), .err_vld(ev[0]), .err_cpu_idx(ei_a),
        .err_exp(ee[0]), .err_got(eg[0]), .halted(hl[0]));

    xorshift_stream_checker #(.NUM_CPUS(5), .STOP_ON_ERR(1'b0), .RESYNC_ON_ERR(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en && sel == 1), .clear(clear),
        .in_vld(vld && sel == 1), .in_rdy(rdy[1]), .in_cpu_idx(idx_s), .in_data(data),
        .match_cnt(mc[1]), .err_cnt(ec[1]), .err_vld(ev[1]), .err_cpu_idx(ei_b),
        .err_exp(ee[1]), .err_got(eg[1]), .halted(hl[1]));

    xorshift_stream_checker #(.NUM_CPUS(4), .STOP_ON_ERR(1'b1), .RESYNC_ON_ERR(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(en && sel == 2), .clear(clear),
        .in_vld(vld && sel == 2), .in_rdy(rdy[2]), .in_cpu_idx(idx_s[1:0]), .in_data(data),
        .match_cnt(mc[2]), .err_cnt(ec[2]), .err_vld(ev[2]), .err_cpu_idx(ei_c),
        .err_exp(ee[2]), .err_got(eg[2]), .halted(hl[2]));

    assign ei[0] = {1'b0, ei_a};
    assign ei[1] = ei_b;
    assign ei[2] = {1'b0, ei_c};

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: expected state per CPU plus the scoreboard the DUT should show
    logic [63:0] m_st [8];
    int          m_match, m_err, m_eidx, ncpu;
    bit          m_ev, m_halt, resync, stop;
    logic [63:0] m_eexp, m_egot;

    function automatic logic [63:0] ref_step(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x * 64'd8192);
        y = y ^ (y / 64'd128);
        y = y ^ (y * 64'd131072);
        return y;
    endfunction

    function automatic logic [63:0] good(input int c);
        return ref_step(m_st[c]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_st[i] = SEED + 64'(i);
        m_match = 0; m_err = 0; m_ev = 0; m_eidx = 0; m_eexp = 0; m_egot = 0; m_halt = 0;
    endtask

    task automatic model_take(input int c, input logic [63:0] d);
        logic [63:0] e;
        e = (c < ncpu) ? ref_step(m_st[c]) : 64'd0;
        if (c < ncpu && e == d) m_match++;
        else begin
            m_err++;
            if (stop) m_halt = 1;
            if (!m_ev) begin m_ev = 1; m_eidx = c; m_eexp = e; m_egot = d; end
        end
        if (c < ncpu) m_st[c] = (e != d && resync) ? ref_step(d) : e;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string t);
        chk({t, "_match"}, 64'(mc[sel]), 64'(m_match));
        chk({t, "_err"}, 64'(ec[sel]), 64'(m_err));
        chk({t, "_errvld"}, 64'(ev[sel]), 64'(m_ev));
        chk({t, "_erridx"}, 64'(ei[sel]), 64'(m_eidx));
        chk({t, "_errexp"}, ee[sel], m_eexp);
        chk({t, "_errgot"}, eg[sel], m_egot);
        chk({t, "_halted"}, 64'(hl[sel]), 64'(m_halt));
    endtask

    task automatic xfer(input int c, input logic [63:0] d, output bit waited);
        int n = 0;
        @(negedge clk);
        vld = 1; idx_s = 3'(c); data = d; waited = 0;
        while (!rdy[sel] && n < 20) begin @(negedge clk); n++; waited = 1; end
        if (n == 20) begin
            n_cmp++; n_fail++;
            $error("FAIL xfer_timeout: observed in_rdy 0 for 20 cycles expected 1");
            vld = 0;
            return;
        end
        @(posedge clk);
        model_take(c, d);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        vld = 0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        vld = 0; clear = 1;
        @(negedge clk);
        clear = 0;
        model_reset();
    endtask

    task automatic set_dut(input int s, input int n, input bit rs, input bit st);
        sel = s; ncpu = n; resync = rs; stop = st;
        do_clear();
    endtask

    initial begin
        bit w, any_w;
        int rot, c;
        logic [63:0] d;
        rst_n = 0; en = 0; clear = 0; vld = 0; idx_s = 0; data = 0; sel = 0;
        ncpu = 4; resync = 0; stop = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("rst");
        chk("rst_rdy", 64'(rdy[0]), 64'd0);
        rst_n = 1;
        en = 1;

        // 3 words per CPU, interleaved with a random rotation
        rot = $urandom_range(0, 3);
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 4; k++) begin
                c = (k + rot) % 4;
                xfer(c, good(c), w);
            end
        idle(2);
        chk("t1_match12", 64'(mc[0]), 64'd12);
        check_all("t1");

        // CPU 2 word #2 corrupted in bit 0
        do_clear();
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < 4; k++)
                xfer(k, good(k) ^ ((r == 1 && k == 2) ? 64'd1 : 64'd0), w);
        idle(2);
        chk("t2_match11", 64'(mc[0]), 64'd11);
        chk("t2_err1", 64'(ec[0]), 64'd1);
        chk("t2_idx2", 64'(ei[0]), 64'd2);
        chk("t2_got_flip", eg[0], ee[0] ^ 64'd1);
        check_all("t2");

        // 100 back-to-back words from CPU 0 with in_vld held high
        do_clear();
        any_w = 0;
        for (int i = 0; i < 100; i++) begin
            xfer(0, good(0), w);
            if (i > 0) any_w |= w;
        end
        idle(2);
        chk("t3_rdy_never_low", 64'(any_w), 64'd0);
        chk("t3_match100", 64'(mc[0]), 64'd100);
        check_all("t3");

        // Random CPUs with occasional single-bit corruption
        do_clear();
        for (int i = 0; i < 40; i++) begin
            c = $urandom_range(0, 3);
            d = good(c);
            if ($urandom_range(0, 5) == 0) d[$urandom_range(0, 63)] ^= 1'b1;
            xfer(c, d, w);
        end
        idle(2);
        check_all("t4");

        // Async reset with the stage full mid-stream
        do_clear();
        xfer(1, good(1), w);
        xfer(2, good(2), w);
        xfer(3, good(3), w);
        #2;
        rst_n = 0; vld = 0;
        #1;
        model_reset();
        check_all("t5_rst");
        chk("t5_rdy", 64'(rdy[0]), 64'd0);
        @(negedge clk);
        rst_n = 1;
        xfer(0, good(0), w);
        idle(2);
        chk("t5_restart_match", 64'(mc[0]), 64'd1);
        check_all("t5");

        // Stop on error: mismatch on word 5
        set_dut(2, 4, 0, 1);
        for (int k = 0; k < 4; k++) xfer(k, good(k), w);
        xfer(0, good(0) ^ (64'd1 << $urandom_range(0, 63)), w);
        idle(1);
        chk("t6_not_yet_halted", 64'(hl[2]), 64'd0);
        @(negedge clk);
        chk("t6_halted", 64'(hl[2]), 64'd1);
        check_all("t6");
        vld = 1;
        #1;
        chk("t6_rdy_halt", 64'(rdy[2]), 64'd0);
        vld = 0;
        do_clear();
        chk("t6_clr_rdy", 64'(rdy[2]), 64'd0);
        check_all("t6_clr");

        // Invalid CPU index then resync behaviour (5-CPU instance)
        set_dut(1, 5, 1, 0);
        xfer(5, {$urandom, $urandom}, w);
        idle(2);
        chk("t7_err1", 64'(ec[1]), 64'd1);
        chk("t7_exp0", ee[1], 64'd0);
        chk("t7_idx5", 64'(ei[1]), 64'd5);
        xfer(1, SEED ^ 64'd0, w);
        xfer(1, good(1), w);
        xfer(3, good(3) ^ 64'h8000_0000_0000_0000, w);
        xfer(3, good(3), w);
        xfer(3, good(3), w);
        idle(2);
        check_all("t7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
